touch_area_decoder: RTL

- Upstream front-end of the vending trade controller.
- Converts raw touch-panel samples (x/y coordinate plus valid) into debounced, single-cycle area event codes on area_flag (1..18).
- Keeps the currently selected goods index on goods_index.
- The trade controller consumes both signals directly and relies on area_flag being a one-cycle pulse, so it never sees a repeated event per press.

---
 rtl/vend_pkg.sv | 34 +++
 rtl/area_map.sv | 67 ++++++
 rtl/touch_area_decoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending trade controller front-end:
// area event codes, touch screen geometry and decoder FSM states.
package vend_pkg;

    localparam logic [4:0] AREA_NONE      = 5'd0;
    localparam logic [4:0] AREA_GOODS_MIN = 5'd1;
    localparam logic [4:0] AREA_GOODS_MAX = 5'd12;
    localparam logic [4:0] AREA_COIN_HALF = 5'd13;
    localparam logic [4:0] AREA_COIN_1    = 5'd14;
    localparam logic [4:0] AREA_COIN_5    = 5'd15;
    localparam logic [4:0] AREA_CLEAR     = 5'd16;
    localparam logic [4:0] AREA_CONFIRM   = 5'd17;
    localparam logic [4:0] AREA_CANCEL    = 5'd18;

    localparam logic [9:0] SCR_W   = 10'd640;
    localparam logic [9:0] SCR_H   = 10'd480;
    localparam logic [9:0] GOODS_W = 10'd480;
    localparam logic [9:0] GOODS_H = 10'd360;
    localparam logic [9:0] CELL    = 10'd120;
    localparam logic [9:0] BTN_W   = 10'd80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_FIRE,
        ST_HOLD,
        ST_RELEASE
    } tad_state_e;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/area_map.sv
// Combinational touch coordinate to region code map (0 = no region).
// Bands are resolved with compare chains so no divider is built.
module area_map
    import vend_pkg::*;
(
    input  logic       valid,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [4:0] region
);

    localparam logic [9:0] C1 = CELL;
    localparam logic [9:0] C2 = 10'(2 * CELL);
    localparam logic [9:0] C3 = 10'(3 * CELL);
    localparam logic [9:0] B1 = BTN_W;
    localparam logic [9:0] B2 = 10'(2 * BTN_W);
    localparam logic [9:0] B3 = 10'(3 * BTN_W);
    localparam logic [9:0] B4 = 10'(4 * BTN_W);
    localparam logic [9:0] B5 = 10'(5 * BTN_W);

    logic [1:0] col;
    logic [1:0] row;
    logic [2:0] btn;

    always_comb begin
        col = 2'd3;
        unique case (1'b1)
            (x < C1):             col = 2'd0;
            (x >= C1 && x < C2):  col = 2'd1;
            (x >= C2 && x < C3):  col = 2'd2;
            default:              col = 2'd3;
        endcase
    end

    always_comb begin
        row = 2'd2;
        unique case (1'b1)
            (y < C1):             row = 2'd0;
            (y >= C1 && y < C2):  row = 2'd1;
            default:              row = 2'd2;
        endcase
    end

    always_comb begin
        btn = 3'd5;
        unique case (1'b1)
            (x < B1):             btn = 3'd0;
            (x >= B1 && x < B2):  btn = 3'd1;
            (x >= B2 && x < B3):  btn = 3'd2;
            (x >= B3 && x < B4):  btn = 3'd3;
            (x >= B4 && x < B5):  btn = 3'd4;
            default:              btn = 3'd5;
        endcase
    end

    // Goods grid above the button strip; anything off-grid is region 0.
    always_comb begin
        region = AREA_NONE;
        if (valid && x < GOODS_W && x < SCR_W) begin
            if (y < GOODS_H)
                region = AREA_GOODS_MIN + {1'b0, row, 2'b00} + {3'b000, col};
            else if (y < SCR_H)
                region = AREA_COIN_HALF + {2'b00, btn};
        end
    end

endmodule

// File: rtl/touch_area_decoder.sv
// Debounces touch samples into one-cycle area events and tracks the
// selected goods index for the trade controller.
module touch_area_decoder
    import vend_pkg::*;
#(
    parameter int DEB_CYCLES = 200000,
    parameter int REL_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       touch_valid,
    input  logic [9:0] touch_x,
    input  logic [9:0] touch_y,
    output logic [4:0] area_flag,
    output logic [3:0] goods_index,
    output logic       busy
);

    localparam int CNT_MAX = max_i(DEB_CYCLES, REL_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DEB_C   = CW'(DEB_CYCLES);
    localparam logic [CW-1:0] REL_C   = CW'(REL_CYCLES);
    localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);

    logic          v_q;
    logic [9:0]    x_q;
    logic [9:0]    y_q;
    logic [4:0]    region;

    tad_state_e    state, state_nxt;
    logic [4:0]    cand, cand_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [4:0]    flag_nxt;
    logic [3:0]    goods_nxt;

    area_map u_area_map (
        .valid  (v_q),
        .x      (x_q),
        .y      (y_q),
        .region (region)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
            x_q <= '0;
            y_q <= '0;
        end else begin
            v_q <= touch_valid;
            x_q <= touch_x;
            y_q <= touch_y;
        end
    end

    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        flag_nxt  = AREA_NONE;
        goods_nxt = goods_index;
        unique case (state)
            ST_IDLE: begin
                if (v_q && region != AREA_NONE) begin
                    state_nxt = ST_DEBOUNCE;
                    cand_nxt  = region;
                    cnt_nxt   = CW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (!v_q || region == AREA_NONE) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (region != cand) begin
                    cand_nxt = region;
                    cnt_nxt  = CW'(1);
                end else if (cnt == DEB_C) begin
                    state_nxt = ST_FIRE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_FIRE: begin
                state_nxt = ST_HOLD;
                flag_nxt  = cand;
                if (cand >= AREA_GOODS_MIN && cand <= AREA_GOODS_MAX)
                    goods_nxt = cand[3:0];
                else if (cand == AREA_CLEAR || cand == AREA_CANCEL)
                    goods_nxt = 4'd0;
            end
            ST_HOLD: begin
                // The finger may slide across regions; only lift-off matters.
                if (!v_q) begin
                    state_nxt = ST_RELEASE;
                    cnt_nxt   = CW'(1);
                end
            end
            ST_RELEASE: begin
                if (v_q) begin
                    state_nxt = ST_HOLD;
                end else if (cnt == REL_C) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cand        <= AREA_NONE;
            cnt         <= '0;
            area_flag   <= AREA_NONE;
            goods_index <= 4'd0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cand        <= cand_nxt;
            cnt         <= cnt_nxt;
            area_flag   <= flag_nxt;
            goods_index <= goods_nxt;
            busy        <= (state_nxt != ST_IDLE);
        end
    end

endmodule
